// File: rtl/if_pkg.sv
// if_pkg: shared constants and state encoding for the instruction-fetch stage.
// Contents: NOP_INSTR (bubble encoding), DEFAULT_RESET_PC, state_t (RUN/MISS_WAIT/REDIRECT_PENDING).
package if_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {
        RUN              = 2'd0,
        MISS_WAIT        = 2'd1,
        REDIRECT_PENDING = 2'd2
    } state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load / hold / bubble controls.
// Ports: clock, reset (async, active-high); load captures next_pc/next_instruction as a valid entry;
// bubble clears valid and drives NOP_INSTR (takes priority over load); neither holds.
// Outputs valid, pc, pc_plus4, instruction feed decode.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] next_pc,
    input  logic [31:0] next_instruction,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instruction
);
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            valid       <= 1'b0;
            pc          <= 32'h0;
            pc_plus4    <= 32'h0;
            instruction <= NOP_INSTR;
        end else if (bubble) begin
            valid       <= 1'b0;
            instruction <= NOP_INSTR;
        end else if (load) begin
            valid       <= 1'b1;
            pc          <= next_pc;
            pc_plus4    <= next_pc + 32'd4;
            instruction <= next_instruction;
        end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32 instruction-fetch stage; owns the PC, sequences around icache misses,
// applies EX redirects and loads the IF/ID register.
// Ports: clock, reset (async, active-high); icache_address/icache_instruction/icache_busywait to the icache;
// stall from the hazard unit; redirect_valid/redirect_target from EX; if_id_* to decode.
// Optional: `define IF_PERF_CNT_EN adds perf_fetched and perf_miss_cycles counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = if_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] icache_address,
    input  logic [31:0] icache_instruction,
    input  logic        icache_busywait,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instruction
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_miss_cycles
`endif
);
    import if_pkg::*;

    state_t      state, next_state;
    logic [31:0] pc, next_pc, pending, next_pending, target;
    logic        load, bubble;

    assign target         = redirect_target & ~32'h3;
    assign icache_address = pc;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state   <= RUN;
            pc      <= RESET_PC;
            pending <= 32'h0;
        end else begin
            state   <= next_state;
            pc      <= next_pc;
            pending <= next_pending;
        end

    // The PC never moves while busywait is high, so the icache fills the line it was asked for.
    always_comb begin
        next_state   = state;
        next_pc      = pc;
        next_pending = pending;
        if (state == REDIRECT_PENDING) begin
            if (icache_busywait) begin
                if (redirect_valid) next_pending = target;
            end else begin
                next_pc    = redirect_valid ? target : pending;
                next_state = RUN;
            end
        end else if (redirect_valid) begin
            if (icache_busywait) begin
                next_pending = target;
                next_state   = REDIRECT_PENDING;
            end else begin
                next_pc    = target;
                next_state = RUN;
            end
        end else if (icache_busywait) begin
            next_state = MISS_WAIT;
        end else if (!stall) begin
            next_pc    = pc + 32'd4;
            next_state = RUN;
        end
    end

    // Redirects and pending redirects squash the fetched word; a stalled miss holds IF/ID instead.
    always_comb begin
        load   = state != REDIRECT_PENDING && !redirect_valid && !icache_busywait && !stall;
        bubble = state == REDIRECT_PENDING || redirect_valid || (icache_busywait && !stall);
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clock           (clock),
        .reset           (reset),
        .load            (load),
        .bubble          (bubble),
        .next_pc         (pc),
        .next_instruction(icache_instruction),
        .valid           (if_id_valid),
        .pc              (if_id_pc),
        .pc_plus4        (if_id_pc_plus4),
        .instruction     (if_id_instruction)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            perf_fetched     <= 32'h0;
            perf_miss_cycles <= 32'h0;
        end else begin
            perf_fetched     <= perf_fetched + {31'h0, load};
            perf_miss_cycles <= perf_miss_cycles + {31'h0, icache_busywait};
        end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench for if_fetch_stage with directed fetch/miss/redirect/stall vectors.
module tb_if_fetch_stage;
    import if_pkg::*;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] addr;
        string       nm;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] icache_address, icache_instruction, redirect_target;
    logic        icache_busywait, stall, redirect_valid;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instruction;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_miss_cycles;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t e;

    if_fetch_stage dut (
        .clock             (clock),
        .reset             (reset),
        .icache_address    (icache_address),
        .icache_instruction(icache_instruction),
        .icache_busywait   (icache_busywait),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_miss_cycles  (perf_miss_cycles)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[11:0], 20'h00093};
    endfunction

    task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at a negedge and queue what IF/ID and the address must show after the edge.
    task automatic step(input logic bw, input logic st, input logic rv, input logic [31:0] rt,
                        input logic ev, input logic [31:0] epc, input logic [31:0] eaddr, input string nm);
        icache_busywait    = bw;
        stall              = st;
        redirect_valid     = rv;
        redirect_target    = rt;
        icache_instruction = bw ? 32'hDEAD_BEEF : img(icache_address);
        q.push_back('{ev, epc, eaddr, nm});
        @(negedge clock);
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm,
                {if_id_valid, if_id_instruction, icache_address,
                 if_id_valid ? if_id_pc : 32'h0, if_id_valid ? if_id_pc_plus4 : 32'h0},
                {e.v, e.v ? img(e.pc) : NOP_INSTR, e.addr,
                 e.v ? e.pc : 32'h0, e.v ? e.pc + 32'd4 : 32'h0});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; icache_busywait = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; icache_instruction = 32'h0;
        #1;
        chk("reset_state", {if_id_valid, if_id_instruction, icache_address, if_id_pc, if_id_pc_plus4},
            {1'b0, NOP_INSTR, 32'h0, 32'h0, 32'h0});
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0, 0, 1, 32'h00, 32'h04, "hit0");
        step(0, 0, 0, 0, 1, 32'h04, 32'h08, "hit4");
        step(0, 0, 0, 0, 1, 32'h08, 32'h0C, "hit8");
        step(0, 0, 0, 0, 1, 32'h0C, 32'h10, "hitC");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 32'h10, "miss10_bubble");
        step(0, 0, 0, 0, 1, 32'h10, 32'h14, "miss10_fill");
        step(0, 0, 0, 0, 1, 32'h14, 32'h18, "hit14");
        step(0, 0, 0, 0, 1, 32'h18, 32'h1C, "hit18");
        step(0, 0, 0, 0, 1, 32'h1C, 32'h20, "hit1C");
        step(0, 0, 1, 32'h100, 0, 0, 32'h100, "redir100_bubble");
        step(0, 0, 0, 0, 1, 32'h100, 32'h104, "hit100");
        step(0, 0, 1, 32'h40, 0, 0, 32'h40, "redir40");
        step(1, 0, 1, 32'h200, 0, 0, 32'h40, "miss40_redir200");
        step(1, 0, 1, 32'h300, 0, 0, 32'h40, "miss40_redir300");
        step(1, 0, 0, 0, 0, 0, 32'h40, "miss40_wait");
        step(0, 0, 0, 0, 0, 0, 32'h300, "miss40_discard");
        step(0, 0, 0, 0, 1, 32'h300, 32'h304, "hit300");
        step(0, 0, 1, 32'h04, 0, 0, 32'h04, "redir4");
        step(0, 0, 0, 0, 1, 32'h04, 32'h08, "hit4b");
        step(0, 1, 0, 0, 1, 32'h04, 32'h08, "stall_hold");
        step(0, 1, 1, 32'h80, 0, 0, 32'h80, "stall_redir80");
        step(0, 1, 0, 0, 0, 0, 32'h80, "stall_hold_bubble");
        step(0, 0, 0, 0, 1, 32'h80, 32'h84, "hit80");
        step(1, 1, 0, 0, 1, 32'h80, 32'h84, "miss_stall_hold");
        step(0, 0, 0, 0, 1, 32'h84, 32'h88, "hit84");
        step(0, 0, 1, 32'hA3, 0, 0, 32'hA0, "redir_lowbits");
        step(0, 0, 0, 0, 1, 32'hA0, 32'hA4, "hitA0");
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, "redir_top");
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, "hit_wrap");
        step(0, 0, 0, 0, 1, 32'h0, 32'h4, "hit_after_wrap");
        step(0, 0, 1, 32'h50, 0, 0, 32'h50, "redir50");
        step(1, 0, 0, 0, 0, 0, 32'h50, "miss50");
        step(1, 0, 1, 32'h200, 0, 0, 32'h50, "miss50_redir200");
        #2;
        reset = 1'b1;
        #1;
        chk("reset_midmiss", {if_id_valid, if_id_instruction, icache_address, if_id_pc, if_id_pc_plus4},
            {1'b0, NOP_INSTR, 32'h0, 32'h0, 32'h0});
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0, 0, 1, 32'h0, 32'h4, "post_reset_hit0");
        step(0, 0, 0, 0, 1, 32'h4, 32'h8, "post_reset_hit4");
        @(posedge clock);
        #2;
        chk("queue_drained", 129'(q.size()), 129'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the RV32 pipeline, directly upstream of the instruction cache.
- Owns the PC and drives the fetch address to the icache.
- Sequences around icache busywait and applies branch/jump redirects from EX.
- Loads the IF/ID pipeline register consumed by decode.
- Holds the address stable for the whole of a cache miss, so the line the icache fills belongs to the requested address.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) driven into IF/ID on a bubble.

Ports:
clock  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high.
icache_address  out  32  fetch address; equals PC.
icache_instruction  in  32  instruction from icache; valid when icache_busywait=0.
icache_busywait  in  1  icache miss in progress; asserted combinationally in the miss-detect cycle.
stall  in  1  hazard-unit stall: hold PC and IF/ID.
redirect_valid  in  1  one-cycle pulse: taken branch/jump from EX.
redirect_target  in  32  redirect PC; bits [1:0] ignored (forced 0).
if_id_valid  out  1  IF/ID holds a real instruction.
if_id_pc  out  32  PC of the IF/ID instruction.
if_id_pc_plus4  out  32  if_id_pc + 4.
if_id_instruction  out  32  instruction, or NOP_INSTR when invalid.

Behaviour:
- Interface decision: reset is named reset, asynchronous, active-high; clock is named clock.
- Reset values:
  - PC = RESET_PC, state = RUN.
  - if_id_valid = 0, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_instruction = NOP_INSTR.
  - pending target = 0.
- icache_address = PC at all times (combinational).
- States: RUN, MISS_WAIT, REDIRECT_PENDING.
- RUN, busywait=0, stall=0, no redirect:
  - At the edge, IF/ID loads {valid=1, PC, PC+4, instruction}; PC <= PC+4.
  - Throughput is 1 instruction/cycle on hits; IF/ID latency is 1 edge.
- RUN, busywait=1, no redirect:
  - Go to MISS_WAIT; PC holds.
  - IF/ID loads a bubble, unless stall=1, in which case it holds.
- MISS_WAIT:
  - PC and address are frozen; each cycle loads a bubble (stall=1 holds instead).
  - When busywait=0, behave as RUN that cycle (accept the instruction, PC+4) and return to RUN.
- stall=1 with busywait=0, no redirect: PC and IF/ID hold; state unchanged.
- Redirect, busywait=0, any state except REDIRECT_PENDING:
  - PC <= target; IF/ID <= bubble (the fetched instruction is wrong-path and is discarded).
  - State <= RUN.
  - Redirect overrides stall.
- Redirect with busywait=1:
  - Latch target into the pending register; state <= REDIRECT_PENDING.
  - PC (address) is NOT changed while busywait=1.
- REDIRECT_PENDING:
  - IF/ID bubble each cycle; a new redirect overwrites the pending target (newest wins).
  - When busywait=0, the returned instruction is discarded; PC <= pending target; state <= RUN.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
- Reset mid-miss: PC returns to RESET_PC immediately and any pending redirect is lost. The icache is reset in parallel.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds outputs perf_fetched (32) and perf_miss_cycles (32), both reset to 0.
  - perf_fetched increments on each valid IF/ID load.
  - perf_miss_cycles increments on each cycle with busywait=1.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package if_pkg:
  - NOP_INSTR constant.
  - Default RESET_PC.
  - State encoding, 2-bit: RUN=0, MISS_WAIT=1, REDIRECT_PENDING=2.
- One sub-module is natural: if_id_reg, the IF/ID register with load/hold/bubble controls and async reset.
- PC/FSM logic stays in the top.

Test Plan:
- Reset, then 4 hit cycles (busywait=0) → if_id_pc 0,4,8,12 on successive edges, valid=1, instructions match the memory image.
- Miss at PC=0x10 with busywait held high 5 cycles → icache_address stays 0x10 throughout, 5 bubbles (NOP, valid=0), then if_id_pc=0x10 valid, next PC 0x14.
- Redirect to 0x100 during a hit at PC=0x20 → next IF/ID is a bubble, icache_address=0x100 next cycle, following if_id_pc=0x100.
- Redirect to 0x200, then 0x300, both during a miss at 0x40 → address stays 0x40 until busywait falls; the 0x40 instruction is discarded; PC becomes 0x300.
- stall=1 for 3 cycles at PC=0x8 with redirect to 0x80 in the 2nd cycle → IF/ID holds in cycle 1, bubble in cycle 2, PC=0x80.
- Reset asserted mid-miss at PC=0x50 → outputs return to reset values asynchronously; PC=RESET_PC after release.
